// File: rtl/lsu_axi_bridge_pkg.sv
// Shared types and AXI constants for the LSU-to-AXI4 bridge.
package lsu_axi_bridge_pkg;

  localparam int AXI_DATA_W = 64;
  localparam int AXI_STRB_W = 8;
  localparam int AXI_ID_W   = 4;

  localparam logic [7:0] AXI_LEN_1BEAT = 8'd0;
  localparam logic [2:0] AXI_SIZE_8B   = 3'b011;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_WR_DONE = 3'd3,
    ST_RD_REQ  = 3'd4,
    ST_RD_DATA = 3'd5,
    ST_RD_DONE = 3'd6
  } state_e;

  // Right-align the addressed bytes so the memory stage extends from bit 0.
  function automatic logic [AXI_DATA_W-1:0] align_rdata(input logic [AXI_DATA_W-1:0] d,
                                                        input logic [2:0] off);
    return d >> {off, 3'b000};
  endfunction

endpackage

// File: rtl/lsu_axi_bridge_if.sv
// AXI4 bus bundle (single-beat subset used by the LSU bridge).
interface lsu_axi_bridge_if #(
  parameter int ADDR_W = 32
);
  import lsu_axi_bridge_pkg::*;

  logic                  awvalid, awready;
  logic [ADDR_W-1:0]     awaddr;
  logic [AXI_ID_W-1:0]   awid;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;

  logic                  wvalid, wready, wlast;
  logic [AXI_DATA_W-1:0] wdata;
  logic [AXI_STRB_W-1:0] wstrb;

  logic                  bvalid, bready;
  logic [1:0]            bresp;
  logic [AXI_ID_W-1:0]   bid;

  logic                  arvalid, arready;
  logic [ADDR_W-1:0]     araddr;
  logic [AXI_ID_W-1:0]   arid;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;

  logic                  rvalid, rready, rlast;
  logic [AXI_DATA_W-1:0] rdata;
  logic [1:0]            rresp;
  logic [AXI_ID_W-1:0]   rid;

  modport master (
    output awvalid, awaddr, awid, awlen, awsize, awburst, input awready,
    output wvalid, wdata, wstrb, wlast, input wready,
    input  bvalid, bresp, bid, output bready,
    output arvalid, araddr, arid, arlen, arsize, arburst, input arready,
    input  rvalid, rdata, rresp, rlast, rid, output rready
  );

  modport slave (
    input  awvalid, awaddr, awid, awlen, awsize, awburst, output awready,
    input  wvalid, wdata, wstrb, wlast, output wready,
    output bvalid, bresp, bid, input bready,
    input  arvalid, araddr, arid, arlen, arsize, arburst, output arready,
    output rvalid, rdata, rresp, rlast, rid, input rready
  );

endinterface

// File: rtl/lsu_axi_bridge.sv
// LSU -> AXI4 master bridge: one single-beat transaction outstanding at a time.
// Optional feature macro: LSU_AXI_RESP_CHECK_EN (non-OKAY bresp/rresp sets sticky bus_err).
module lsu_axi_bridge
  import lsu_axi_bridge_pkg::*;
#(
  parameter int                  AXI_ADDR_W = 32,
  parameter logic [AXI_ID_W-1:0] AXI_ID     = '0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        w_valid_i,
  output logic        w_ready_o,
  input  logic [63:0] w_addr_i,
  input  logic [63:0] w_data_i,
  input  logic [7:0]  w_mask_i,
  output logic        w_valid_o,
  input  logic        w_ready_i,
  input  logic        r_valid_i,
  output logic        r_ready_o,
  input  logic [63:0] r_addr_i,
  output logic [63:0] data_read_o,
  output logic        data_valid,
  input  logic        data_ready,
  lsu_axi_bridge_if.master axi,
  output logic        bus_err
);

  state_e                state_q;
  logic                  rdy_q;
  logic                  awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic                  aw_done_q, w_done_q;
  logic                  wdone_q, dvalid_q;
  logic [AXI_ADDR_W-1:0] addr_q;
  logic [2:0]            off_q;
  logic [AXI_DATA_W-1:0] wdata_q, rdata_q;
  logic [AXI_STRB_W-1:0] wstrb_q;
  logic                  err_q;
  logic                  aw_hs, w_hs;

  assign aw_hs = axi.awvalid & axi.awready;
  assign w_hs  = axi.wvalid & axi.wready;

  // Front end: write has priority, so a same-cycle read is held off.
  assign w_ready_o   = rdy_q;
  assign r_ready_o   = rdy_q & ~w_valid_i;
  assign w_valid_o   = wdone_q;
  assign data_valid  = dvalid_q;
  assign data_read_o = rdata_q;

  assign axi.awvalid = awvalid_q;
  assign axi.awaddr  = addr_q;
  assign axi.awid    = AXI_ID;
  assign axi.awlen   = AXI_LEN_1BEAT;
  assign axi.awsize  = AXI_SIZE_8B;
  assign axi.awburst = AXI_BURST_INCR;
  assign axi.wvalid  = wvalid_q;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = wstrb_q;
  assign axi.wlast   = 1'b1;
  assign axi.bready  = bready_q;
  assign axi.arvalid = arvalid_q;
  assign axi.araddr  = addr_q;
  assign axi.arid    = AXI_ID;
  assign axi.arlen   = AXI_LEN_1BEAT;
  assign axi.arsize  = AXI_SIZE_8B;
  assign axi.arburst = AXI_BURST_INCR;
  assign axi.rready  = rready_q;

  // Transaction FSM; every handshake output is a register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      rdy_q     <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      wdone_q   <= 1'b0;
      dvalid_q  <= 1'b0;
      addr_q    <= '0;
      off_q     <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rdy_q && w_valid_i) begin
            rdy_q     <= 1'b0;
            addr_q    <= {w_addr_i[AXI_ADDR_W-1:3], 3'b000};
            off_q     <= w_addr_i[2:0];
            wdata_q   <= w_data_i;
            wstrb_q   <= w_mask_i;
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            state_q   <= ST_WR_REQ;
          end else if (rdy_q && r_valid_i) begin
            rdy_q     <= 1'b0;
            addr_q    <= {r_addr_i[AXI_ADDR_W-1:3], 3'b000};
            off_q     <= r_addr_i[2:0];
            arvalid_q <= 1'b1;
            state_q   <= ST_RD_REQ;
          end else begin
            rdy_q <= 1'b1;
          end
        end
        ST_WR_REQ: begin
          if (aw_hs) begin
            awvalid_q <= 1'b0;
            aw_done_q <= 1'b1;
          end
          if (w_hs) begin
            wvalid_q <= 1'b0;
            w_done_q <= 1'b1;
          end
          if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
            bready_q <= 1'b1;
            state_q  <= ST_WR_RESP;
          end
        end
        ST_WR_RESP: begin
          if (axi.bvalid) begin
            bready_q <= 1'b0;
            wdone_q  <= 1'b1;
            state_q  <= ST_WR_DONE;
`ifdef LSU_AXI_RESP_CHECK_EN
            if (axi.bresp != AXI_RESP_OKAY) err_q <= 1'b1;
`endif
          end
        end
        ST_WR_DONE: begin
          if (w_ready_i) begin
            wdone_q <= 1'b0;
            rdy_q   <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        ST_RD_REQ: begin
          if (axi.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= ST_RD_DATA;
          end
        end
        ST_RD_DATA: begin
          if (axi.rvalid) begin
            rready_q <= 1'b0;
            rdata_q  <= align_rdata(axi.rdata, off_q);
            dvalid_q <= 1'b1;
            state_q  <= ST_RD_DONE;
`ifdef LSU_AXI_RESP_CHECK_EN
            if (axi.rresp != AXI_RESP_OKAY) err_q <= 1'b1;
`endif
          end
        end
        ST_RD_DONE: begin
          if (data_ready) begin
            dvalid_q <= 1'b0;
            rdy_q    <= 1'b1;
            state_q  <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef LSU_AXI_RESP_CHECK_EN
  assign bus_err = err_q;
  logic unused_sig;
  assign unused_sig = ^{w_addr_i[63:AXI_ADDR_W], r_addr_i[63:AXI_ADDR_W],
                        axi.rlast, axi.rid, axi.bid};
`else
  assign bus_err = 1'b0;
  logic unused_sig;
  assign unused_sig = ^{w_addr_i[63:AXI_ADDR_W], r_addr_i[63:AXI_ADDR_W],
                        axi.rlast, axi.rid, axi.bid, axi.bresp, axi.rresp, err_q};
`endif

endmodule

// File: tb/tb_lsu_axi_bridge.sv
// Directed bench for lsu_axi_bridge with a small behavioural AXI slave.
module tb_lsu_axi_bridge;
  import lsu_axi_bridge_pkg::*;

`ifdef LSU_AXI_RESP_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        w_valid_i = 0, w_ready_i = 0, r_valid_i = 0, data_ready = 0;
  logic [63:0] w_addr_i = '0, w_data_i = '0, r_addr_i = '0;
  logic [7:0]  w_mask_i = '0;
  logic        w_ready_o, w_valid_o, r_ready_o, data_valid, bus_err;
  logic [63:0] data_read_o;

  lsu_axi_bridge_if #(.ADDR_W(32)) axi ();

  lsu_axi_bridge #(.AXI_ADDR_W(32), .AXI_ID('0)) dut (
    .clk(clk), .rst_n(rst_n),
    .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_addr_i(w_addr_i),
    .w_data_i(w_data_i), .w_mask_i(w_mask_i),
    .w_valid_o(w_valid_o), .w_ready_i(w_ready_i),
    .r_valid_i(r_valid_i), .r_ready_o(r_ready_o), .r_addr_i(r_addr_i),
    .data_read_o(data_read_o), .data_valid(data_valid), .data_ready(data_ready),
    .axi(axi), .bus_err(bus_err)
  );

  // Slave configuration, set by the tests.
  int          aw_delay = 0;
  logic        r_hold = 0;
  logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic [63:0] rdata_cfg = '0;

  // Slave state.
  int   aw_wait;
  logic s_bvalid, s_rvalid, aw_got, w_got, r_pend;

  assign axi.awready = axi.awvalid && (aw_wait >= aw_delay);
  assign axi.wready  = 1'b1;
  assign axi.bvalid  = s_bvalid;
  assign axi.bresp   = bresp_cfg;
  assign axi.bid     = '0;
  assign axi.arready = 1'b1;
  assign axi.rvalid  = s_rvalid;
  assign axi.rdata   = rdata_cfg;
  assign axi.rresp   = rresp_cfg;
  assign axi.rlast   = 1'b1;
  assign axi.rid     = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_wait <= 0; s_bvalid <= 0; s_rvalid <= 0; aw_got <= 0; w_got <= 0; r_pend <= 0;
    end else begin
      if (axi.awvalid && axi.awready) begin aw_got <= 1; aw_wait <= 0; end
      else if (axi.awvalid) aw_wait <= aw_wait + 1;
      if (axi.wvalid && axi.wready) w_got <= 1;
      if (s_bvalid && axi.bready) s_bvalid <= 0;
      else if (!s_bvalid && (aw_got || (axi.awvalid && axi.awready))
                         && (w_got || (axi.wvalid && axi.wready))) begin
        s_bvalid <= 1; aw_got <= 0; w_got <= 0;
      end
      if (axi.arvalid && axi.arready) begin
        if (r_hold) r_pend <= 1; else s_rvalid <= 1;
      end
      if (r_pend && !r_hold) begin s_rvalid <= 1; r_pend <= 0; end
      if (s_rvalid && axi.rready) s_rvalid <= 0;
    end
  end

  // Bus captures and activity counters.
  logic [31:0] cap_awaddr, cap_araddr;
  logic [63:0] cap_wdata;
  logic [7:0]  cap_wstrb, cap_awlen;
  logic [2:0]  cap_awsize;
  logic [1:0]  cap_awburst;
  logic        cap_wlast;
  int aw_cyc = 0, w_cyc = 0, b_cnt = 0;
  always @(posedge clk) begin
    if (axi.awvalid) aw_cyc <= aw_cyc + 1;
    if (axi.wvalid)  w_cyc  <= w_cyc + 1;
    if (axi.bvalid && axi.bready) b_cnt <= b_cnt + 1;
    if (axi.awvalid && axi.awready) begin
      cap_awaddr <= axi.awaddr; cap_awlen <= axi.awlen;
      cap_awsize <= axi.awsize; cap_awburst <= axi.awburst;
    end
    if (axi.wvalid && axi.wready) begin
      cap_wdata <= axi.wdata; cap_wstrb <= axi.wstrb; cap_wlast <= axi.wlast;
    end
    if (axi.arvalid && axi.arready) cap_araddr <= axi.araddr;
  end

  int vecs = 0, errs = 0;

  // Stimulus helpers (no checking). Called just after a negedge; return at the next one.
  task automatic drive_store(input logic [63:0] a, input logic [63:0] d, input logic [7:0] m);
    w_addr_i = a; w_data_i = d; w_mask_i = m; w_valid_i = 1;
    @(negedge clk); w_valid_i = 0;
  endtask

  task automatic drive_load(input logic [63:0] a);
    r_addr_i = a; r_valid_i = 1;
    @(negedge clk); r_valid_i = 0;
  endtask

  // cyc counts clock cycles with the accept cycle as cycle 1.
  task automatic wait_wdone(output int cyc);
    cyc = 2;
    while (w_valid_o !== 1'b1 && cyc < 60) begin @(negedge clk); cyc++; end
  endtask

  task automatic wait_rdone(output int cyc);
    cyc = 2;
    while (data_valid !== 1'b1 && cyc < 60) begin @(negedge clk); cyc++; end
  endtask

  task automatic ack_w();
    w_ready_i = 1; @(negedge clk); w_ready_i = 0;
  endtask

  task automatic ack_r();
    data_ready = 1; @(negedge clk); data_ready = 0;
  endtask

  task automatic test_reset();
    rst_n = 1; #1 rst_n = 0;
    repeat (2) @(negedge clk);
    vecs++; if (w_ready_o !== 1'b0) begin errs++; $display("FAIL rst_w_ready: got %b want 0", w_ready_o); end
    vecs++; if (r_ready_o !== 1'b0) begin errs++; $display("FAIL rst_r_ready: got %b want 0", r_ready_o); end
    vecs++; if ({axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready} !== 5'b0) begin
      errs++; $display("FAIL rst_axi_valids: got %b want 00000",
                       {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready}); end
    vecs++; if ({w_valid_o, data_valid} !== 2'b0) begin
      errs++; $display("FAIL rst_done_valids: got %b want 00", {w_valid_o, data_valid}); end
    vecs++; if (data_read_o !== 64'h0) begin errs++; $display("FAIL rst_data: got %h want 0", data_read_o); end
    vecs++; if (bus_err !== 1'b0) begin errs++; $display("FAIL rst_bus_err: got %b want 0", bus_err); end
    rst_n = 1;
    @(negedge clk);
    vecs++; if (w_ready_o !== 1'b1) begin errs++; $display("FAIL idle_w_ready: got %b want 1", w_ready_o); end
    vecs++; if (r_ready_o !== 1'b1) begin errs++; $display("FAIL idle_r_ready: got %b want 1", r_ready_o); end
  endtask

  task automatic test_store();
    int cyc;
    drive_store(64'h0000_0000_8000_0004, 64'hAABBCCDD_00000000, 8'hF0);
    wait_wdone(cyc);
    vecs++; if (cyc !== 4) begin errs++; $display("FAIL store_latency: got %0d want 4", cyc); end
    vecs++; if (cap_awaddr !== 32'h8000_0000) begin errs++; $display("FAIL store_awaddr: got %h want 80000000", cap_awaddr); end
    vecs++; if (cap_wstrb !== 8'hF0) begin errs++; $display("FAIL store_wstrb: got %h want f0", cap_wstrb); end
    vecs++; if (cap_wdata !== 64'hAABBCCDD_00000000) begin errs++; $display("FAIL store_wdata: got %h want aabbccdd00000000", cap_wdata); end
    vecs++; if ({cap_awlen, cap_awsize, cap_awburst, cap_wlast} !== {8'd0, 3'b011, 2'b01, 1'b1}) begin
      errs++; $display("FAIL store_consts: got len %h size %b burst %b last %b want 00 011 01 1",
                       cap_awlen, cap_awsize, cap_awburst, cap_wlast); end
    vecs++; if (axi.awid !== 4'd0) begin errs++; $display("FAIL store_awid: got %h want 0", axi.awid); end
    repeat (2) @(negedge clk);
    vecs++; if (w_valid_o !== 1'b1) begin errs++; $display("FAIL store_hold: got %b want 1", w_valid_o); end
    ack_w();
    vecs++; if ({w_valid_o, w_ready_o} !== 2'b01) begin
      errs++; $display("FAIL store_release: got w_valid_o,w_ready_o=%b want 01", {w_valid_o, w_ready_o}); end
  endtask

  task automatic test_load();
    int cyc;
    rdata_cfg = 64'h11223344_55667788;
    drive_load(64'h0000_0000_8000_0003);
    wait_rdone(cyc);
    vecs++; if (cyc !== 4) begin errs++; $display("FAIL load_latency: got %0d want 4", cyc); end
    vecs++; if (cap_araddr !== 32'h8000_0000) begin errs++; $display("FAIL load_araddr: got %h want 80000000", cap_araddr); end
    vecs++; if (data_read_o !== 64'h00000011_22334455) begin errs++; $display("FAIL load_data: got %h want 0000001122334455", data_read_o); end
    repeat (3) @(negedge clk);
    vecs++; if ({data_valid, data_read_o} !== {1'b1, 64'h00000011_22334455}) begin
      errs++; $display("FAIL load_hold: got valid %b data %h want 1 0000001122334455", data_valid, data_read_o); end
    ack_r();
    vecs++; if ({data_valid, r_ready_o} !== 2'b01) begin
      errs++; $display("FAIL load_release: got data_valid,r_ready_o=%b want 01", {data_valid, r_ready_o}); end
  endtask

  task automatic test_collision();
    int cyc;
    rdata_cfg = 64'hCAFEF00D_12345678;
    w_addr_i = 64'h8000_0008; w_data_i = 64'h1; w_mask_i = 8'h01; w_valid_i = 1;
    r_addr_i = 64'h8000_0016; r_valid_i = 1;
    #1;
    vecs++; if ({w_ready_o, r_ready_o} !== 2'b10) begin
      errs++; $display("FAIL coll_ready: got w,r=%b want 10", {w_ready_o, r_ready_o}); end
    @(negedge clk); w_valid_i = 0;
    vecs++; if ({axi.awvalid, axi.arvalid} !== 2'b10) begin
      errs++; $display("FAIL coll_write_first: got aw,ar=%b want 10", {axi.awvalid, axi.arvalid}); end
    wait_wdone(cyc);
    vecs++; if (cap_awaddr !== 32'h8000_0008) begin errs++; $display("FAIL coll_awaddr: got %h want 80000008", cap_awaddr); end
    ack_w();
    vecs++; if ({r_ready_o, axi.arvalid} !== 2'b10) begin
      errs++; $display("FAIL coll_idle: got r_ready_o,arvalid=%b want 10", {r_ready_o, axi.arvalid}); end
    @(negedge clk); r_valid_i = 0;
    vecs++; if (axi.arvalid !== 1'b1) begin errs++; $display("FAIL coll_read_start: got %b want 1", axi.arvalid); end
    wait_rdone(cyc);
    vecs++; if (data_read_o !== 64'h00000000_0000CAFE) begin errs++; $display("FAIL coll_data: got %h want 000000000000cafe", data_read_o); end
    ack_r();
  endtask

  task automatic test_aw_delay();
    int cyc, aw0, w0, b0;
    aw0 = aw_cyc; w0 = w_cyc; b0 = b_cnt;
    aw_delay = 2;
    drive_store(64'h8000_0020, 64'h55, 8'hFF);
    wait_wdone(cyc);
    vecs++; if (w_valid_o !== 1'b1) begin errs++; $display("FAIL awdly_timeout: got %b want 1", w_valid_o); end
    vecs++; if (aw_cyc - aw0 !== 3) begin errs++; $display("FAIL awdly_awvalid_cycles: got %0d want 3", aw_cyc - aw0); end
    vecs++; if (w_cyc - w0 !== 1) begin errs++; $display("FAIL awdly_wvalid_cycles: got %0d want 1", w_cyc - w0); end
    vecs++; if (b_cnt - b0 !== 1) begin errs++; $display("FAIL awdly_b_count: got %0d want 1", b_cnt - b0); end
    ack_w();
    aw_delay = 0;
  endtask

  task automatic test_reset_mid_read();
    int cyc;
    r_hold = 1;
    rdata_cfg = 64'h0123456789ABCDEF;
    drive_load(64'h8000_0040);
    cyc = 0;
    while (axi.rready !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
    vecs++; if (axi.rready !== 1'b1) begin errs++; $display("FAIL rstmid_reach_rd_data: got %b want 1", axi.rready); end
    #2 rst_n = 0;
    #1;
    vecs++; if ({axi.rready, axi.arvalid, data_valid, r_ready_o} !== 4'b0) begin
      errs++; $display("FAIL rstmid_abort: got rready,arvalid,dvalid,r_ready=%b want 0000",
                       {axi.rready, axi.arvalid, data_valid, r_ready_o}); end
    @(negedge clk); rst_n = 1; r_hold = 0;
    @(negedge clk);
    drive_load(64'h8000_0041);
    wait_rdone(cyc);
    vecs++; if (cyc !== 4) begin errs++; $display("FAIL rstmid_relatency: got %0d want 4", cyc); end
    vecs++; if (data_read_o !== 64'h00_0123456789ABCD) begin errs++; $display("FAIL rstmid_data: got %h want 000123456789abcd", data_read_o); end
    ack_r();
  endtask

  task automatic test_bus_err();
    int cyc;
    vecs++; if (bus_err !== 1'b0) begin errs++; $display("FAIL err_initial: got %b want 0", bus_err); end
    bresp_cfg = AXI_RESP_SLVERR;
    drive_store(64'h8000_0080, 64'h7, 8'h0F);
    wait_wdone(cyc);
    ack_w();
    vecs++; if (bus_err !== EXP_ERR) begin errs++; $display("FAIL err_slverr: got %b want %b", bus_err, EXP_ERR); end
    bresp_cfg = AXI_RESP_OKAY;
    drive_store(64'h8000_0088, 64'h8, 8'h0F);
    wait_wdone(cyc);
    ack_w();
    vecs++; if (bus_err !== EXP_ERR) begin errs++; $display("FAIL err_sticky: got %b want %b", bus_err, EXP_ERR); end
  endtask

  initial begin
    test_reset();
    test_store();
    test_load();
    test_collision();
    test_aw_delay();
    test_reset_mid_read();
    test_bus_err();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
